coord_marker_overlay: RTL and testbench

//   Consumes the projected sound-source pixel coordinate (x_2d/y_2d) from the 3D->2D

---
 rtl/coord_marker_overlay.sv | 167 ++++++++++++++++
 tb/tb_coord_marker_overlay.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/coord_marker_overlay.sv
// Crosshair overlay for the projected sound-source coordinate on an RGB888 video stream.
// Coordinates are range-checked, held pending, and applied only at frame start.
`timescale 1ns/1ps

module coord_marker_overlay #(
    parameter int          H_ACT       = 640,
    parameter int          V_ACT       = 480,
    parameter int          COORD_SHIFT = 4,
    parameter int          ARM         = 8,
    parameter int          HOLD_FRAMES = 30,
    parameter logic [23:0] MARK_COLOR  = 24'hFF0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coord_valid,
    input  logic [31:0] x_2d,
    input  logic [31:0] y_2d,
    input  logic        vid_vs,
    input  logic        vid_de,
    input  logic [23:0] vid_rgb,
    output logic        out_vs,
    output logic        out_de,
    output logic [23:0] out_rgb,
    output logic        marker_on,
    output logic        coord_reject
);

    localparam int XW = $clog2(H_ACT);
    localparam int YW = $clog2(V_ACT);
    localparam int XS = XW + 1;
    localparam int YS = YW + 1;
    localparam int MW = $clog2(HOLD_FRAMES + 1);

    localparam logic [XW-1:0]        H_LAST = XW'(H_ACT - 1);
    localparam logic [YW-1:0]        V_LAST = YW'(V_ACT - 1);
    localparam logic [MW-1:0]        HOLD   = MW'(HOLD_FRAMES);
    localparam logic signed [XS-1:0] ARM_X  = XS'(ARM);
    localparam logic signed [YS-1:0] ARM_Y  = YS'(ARM);

    logic [XW-1:0] hcnt_q, hcnt_d;
    logic [YW-1:0] vcnt_q, vcnt_d;
    logic          vs_prev_q, de_prev_q;
    logic [XW-1:0] pend_x_q, pend_x_d, act_x_q, act_x_d;
    logic [YW-1:0] pend_y_q, pend_y_d, act_y_q, act_y_d;
    logic          pend_flag_q, pend_flag_d;
    logic [MW-1:0] miss_cnt_q, miss_cnt_d;
    logic          marker_on_q, marker_on_d;
    logic          coord_reject_q, coord_reject_d;
    logic          out_vs_q, out_de_q;
    logic [23:0]   out_rgb_q, out_rgb_d;

    logic               frame_start, de_fall;
    logic signed [31:0] px, py;
    logic               coord_ok;
    logic signed [XS-1:0] dh;
    logic signed [YS-1:0] dv;
    logic               h_near, v_near, mark_px;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        frame_start = vid_vs & ~vs_prev_q;
        de_fall     = ~vid_de & de_prev_q;

        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (frame_start) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (de_fall) begin
            hcnt_d = '0;
            if (vcnt_q != V_LAST) vcnt_d = vcnt_q + 1'b1;
        end else if (vid_de && hcnt_q != H_LAST) begin
            hcnt_d = hcnt_q + 1'b1;
        end
    end

    always_comb begin
        px       = $signed(x_2d) >>> COORD_SHIFT;
        py       = $signed(y_2d) >>> COORD_SHIFT;
        coord_ok = (px >= 0) && (px < H_ACT) && (py >= 0) && (py < V_ACT);

        pend_x_d       = pend_x_q;
        pend_y_d       = pend_y_q;
        pend_flag_d    = pend_flag_q;
        act_x_d        = act_x_q;
        act_y_d        = act_y_q;
        miss_cnt_d     = miss_cnt_q;
        marker_on_d    = marker_on_q;
        coord_reject_d = coord_valid && !coord_ok;

        // Promotion reads the pending value held before this cycle; a strobe in the
        // same cycle is captured below and waits for the next frame.
        if (frame_start) begin
            if (pend_flag_q) begin
                act_x_d     = pend_x_q;
                act_y_d     = pend_y_q;
                pend_flag_d = 1'b0;
                miss_cnt_d  = '0;
                marker_on_d = 1'b1;
            end else if (miss_cnt_q != HOLD) begin
                miss_cnt_d = miss_cnt_q + 1'b1;
                if (miss_cnt_d == HOLD) marker_on_d = 1'b0;
            end
        end

        if (coord_valid && coord_ok) begin
            pend_x_d    = px[XW-1:0];
            pend_y_d    = py[YW-1:0];
            pend_flag_d = 1'b1;
        end
    end

    // Signed differences let the arms clip at the frame edges instead of wrapping.
    always_comb begin
        dh      = $signed({1'b0, hcnt_q}) - $signed({1'b0, act_x_q});
        dv      = $signed({1'b0, vcnt_q}) - $signed({1'b0, act_y_q});
        h_near  = (dh >= -ARM_X) && (dh <= ARM_X);
        v_near  = (dv >= -ARM_Y) && (dv <= ARM_Y);
        mark_px = marker_on_q && vid_de &&
                  (((vcnt_q == act_y_q) && h_near) || ((hcnt_q == act_x_q) && v_near));
        out_rgb_d = mark_px ? MARK_COLOR : vid_rgb;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q         <= '0;
            vcnt_q         <= '0;
            vs_prev_q      <= 1'b0;
            de_prev_q      <= 1'b0;
            pend_x_q       <= '0;
            pend_y_q       <= '0;
            pend_flag_q    <= 1'b0;
            act_x_q        <= '0;
            act_y_q        <= '0;
            miss_cnt_q     <= '0;
            marker_on_q    <= 1'b0;
            coord_reject_q <= 1'b0;
            out_vs_q       <= 1'b0;
            out_de_q       <= 1'b0;
            out_rgb_q      <= '0;
        end else begin
            hcnt_q         <= hcnt_d;
            vcnt_q         <= vcnt_d;
            vs_prev_q      <= vid_vs;
            de_prev_q      <= vid_de;
            pend_x_q       <= pend_x_d;
            pend_y_q       <= pend_y_d;
            pend_flag_q    <= pend_flag_d;
            act_x_q        <= act_x_d;
            act_y_q        <= act_y_d;
            miss_cnt_q     <= miss_cnt_d;
            marker_on_q    <= marker_on_d;
            coord_reject_q <= coord_reject_d;
            out_vs_q       <= vid_vs;
            out_de_q       <= vid_de;
            out_rgb_q      <= out_rgb_d;
        end
    end

    assign out_vs       = out_vs_q;
    assign out_de       = out_de_q;
    assign out_rgb      = out_rgb_q;
    assign marker_on    = marker_on_q;
    assign coord_reject = coord_reject_q;

endmodule

// File: tb/tb_coord_marker_overlay.sv
// Self-checking bench for coord_marker_overlay: table of per-frame vectors plus
// hand-written timeout, same-cycle update and mid-frame reset sequences.
`timescale 1ns/1ps

module tb_coord_marker_overlay;

    localparam logic [23:0] MARK  = 24'hFF0000;
    localparam logic [23:0] BLANK = 24'h0F0F0F;

    logic        clk = 1'b0;
    logic        rst;
    logic        coord_valid;
    logic [31:0] x_2d, y_2d;
    logic        vid_vs, vid_de;
    logic [23:0] vid_rgb;
    logic        out_vs, out_de;
    logic [23:0] out_rgb;
    logic        marker_on, coord_reject;

    always #5 clk = ~clk;

    coord_marker_overlay dut (
        .clk          (clk),
        .rst          (rst),
        .coord_valid  (coord_valid),
        .x_2d         (x_2d),
        .y_2d         (y_2d),
        .vid_vs       (vid_vs),
        .vid_de       (vid_de),
        .vid_rgb      (vid_rgb),
        .out_vs       (out_vs),
        .out_de       (out_de),
        .out_rgb      (out_rgb),
        .marker_on    (marker_on),
        .coord_reject (coord_reject)
    );

    typedef struct {
        int          ns;      // strobes inserted mid-frame (0..2)
        logic [31:0] x0, y0, x1, y1;
        int          nl;      // lines driven (line 0 is a full 640-pixel line)
        bit          on;      // expected marker_on after this frame's vs edge
        int          ex, ey;  // expected marker centre in pixels
        int          marks;   // expected count of marker pixels in this frame
        int          rej;     // expected coord_reject cycles in this frame
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int frame_bad, frame_marks, frame_rej;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int h, input int v);
        return {h[7:0], v[7:0], 8'hA5};
    endfunction

    function automatic bit is_mark(input int h, input int v, input bit on, input int ex, input int ey);
        int dh, dv;
        dh = (h > ex) ? h - ex : ex - h;
        dv = (v > ey) ? v - ey : ey - v;
        return on && ((v == ey && dh <= 8) || (h == ex && dv <= 8));
    endfunction

    function automatic vec_t mk(input int ns, input logic [31:0] x0, input logic [31:0] y0,
                                input logic [31:0] x1, input logic [31:0] y1, input int nl,
                                input bit on, input int ex, input int ey,
                                input int marks, input int rej);
        vec_t r;
        r.ns = ns; r.x0 = x0; r.y0 = y0; r.x1 = x1; r.y1 = y1; r.nl = nl;
        r.on = on; r.ex = ex; r.ey = ey; r.marks = marks; r.rej = rej;
        return r;
    endfunction

    task automatic step(input logic vs, input logic de, input logic [23:0] rgb,
                        input logic cv, input logic [31:0] x, input logic [31:0] y);
        vid_vs      = vs;
        vid_de      = de;
        vid_rgb     = rgb;
        coord_valid = cv;
        x_2d        = x;
        y_2d        = y;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vs, input logic de, input logic [23:0] rgb,
                         input logic cv, input logic [31:0] x, input logic [31:0] y,
                         input logic [23:0] exp_rgb);
        step(vs, de, rgb, cv, x, y);
        if (out_vs !== vs || out_de !== de || out_rgb !== exp_rgb) begin
            if (frame_bad == 0)
                $display("  first pixel diff: out vs=%b de=%b rgb=%h, wanted vs=%b de=%b rgb=%h",
                         out_vs, out_de, out_rgb, vs, de, exp_rgb);
            frame_bad++;
        end
        if (out_de && out_rgb == MARK) frame_marks++;
        if (coord_reject) frame_rej++;
    endtask

    task automatic gap(input int ns, input logic [31:0] x0, input logic [31:0] y0,
                       input logic [31:0] x1, input logic [31:0] y1);
        for (int b = 0; b < 4; b++) begin
            logic cv;
            logic [31:0] sx, sy;
            cv = (b == 1 && ns >= 1) || (b == 3 && ns >= 2);
            sx = (b == 3) ? x1 : x0;
            sy = (b == 3) ? y1 : y0;
            drive(1'b0, 1'b0, BLANK, cv, sx, sy, BLANK);
        end
    endtask

    task automatic run_frame(input int ns, input logic [31:0] x0, input logic [31:0] y0,
                             input logic [31:0] x1, input logic [31:0] y1,
                             input bit vss, input logic [31:0] vx, input logic [31:0] vy,
                             input int nl, input bit on, input int ex, input int ey);
        frame_bad = 0; frame_marks = 0; frame_rej = 0;
        drive(1'b1, 1'b0, BLANK, vss, vx, vy, BLANK);
        drive(1'b1, 1'b0, BLANK, 1'b0, 32'd0, 32'd0, BLANK);
        drive(1'b0, 1'b0, BLANK, 1'b0, 32'd0, 32'd0, BLANK);
        drive(1'b0, 1'b0, BLANK, 1'b0, 32'd0, 32'd0, BLANK);
        for (int v = 0; v < nl; v++) begin
            int len;
            len = (v == 0) ? 640 : 112;
            for (int h = 0; h < len; h++)
                drive(1'b0, 1'b1, pix(h, v), 1'b0, 32'd0, 32'd0,
                      is_mark(h, v, on, ex, ey) ? MARK : pix(h, v));
            gap((v == nl / 2) ? ns : 0, x0, y0, x1, y1);
        end
        gap((nl == 0) ? ns : 0, x0, y0, x1, y1);
    endtask

    task automatic frame_checks(input string name, input bit on, input int marks, input int rej);
        check({name, "_marker_on"}, int'(marker_on), int'(on));
        check({name, "_marks"}, frame_marks, marks);
        check({name, "_reject"}, frame_rej, rej);
        check({name, "_pixels"}, frame_bad, 0);
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1600, 800, 0, 0, 60, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 60, 1, 100, 50, 33, 0));
        tbl.push_back(mk(1, -16, 800, 0, 0, 4, 1, 100, 50, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 1, 100, 50, 0, 0));
        tbl.push_back(mk(1, 10240, 800, 0, 0, 4, 1, 100, 50, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 60, 1, 100, 50, 33, 0));
        tbl.push_back(mk(1, 320, 160, 0, 0, 4, 1, 100, 50, 0, 0));
        tbl.push_back(mk(2, 480, 640, 560, 720, 20, 1, 20, 10, 33, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 46, 1, 35, 45, 25, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 35, 45, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10, 1, 0, 0, 17, 0));
        tbl.push_back(mk(1, 32'hFFFF_FFFF, 0, 0, 0, 10, 1, 0, 0, 17, 1));
        tbl.push_back(mk(1, 0, 7680, 0, 0, 10, 1, 0, 0, 17, 1));
        tbl.push_back(mk(1, 10239, 7679, 0, 0, 10, 1, 0, 0, 17, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 1, 639, 479, 0, 0));

        // Reset with busy inputs: every output must read zero.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 24'h123456, 1'b1, 32'd1600, 32'd800);
        check("reset_outputs", int'({out_vs, out_de, out_rgb, marker_on, coord_reject}), 0);
        rst = 1'b0;
        step(1'b0, 1'b0, BLANK, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, BLANK, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            run_frame(tbl[i].ns, tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, 1'b0, 32'd0, 32'd0,
                      tbl[i].nl, tbl[i].on, tbl[i].ex, tbl[i].ey);
            frame_checks($sformatf("row%0d", i), tbl[i].on, tbl[i].marks, tbl[i].rej);
        end

        // Timeout: accept (10,5), promote at E0, stay lit through E29, drop at E30.
        run_frame(1, 160, 80, 0, 0, 1'b0, 0, 0, 0, 1'b1, 639, 479);
        frame_checks("to_accept", 1'b1, 0, 0);
        run_frame(0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1, 10, 5);
        frame_checks("to_e0", 1'b1, 0, 0);
        for (int k = 1; k <= 28; k++) begin
            run_frame(0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1, 10, 5);
            check($sformatf("to_e%0d_marker_on", k), int'(marker_on), 1);
        end
        run_frame(0, 0, 0, 0, 0, 1'b0, 0, 0, 14, 1'b1, 10, 5);
        frame_checks("to_e29", 1'b1, 30, 0);
        run_frame(0, 0, 0, 0, 0, 1'b0, 0, 0, 14, 1'b0, 10, 5);
        frame_checks("to_e30", 1'b0, 0, 0);

        // Strobe on the vs-edge cycle: old pending (60,10) shows first, (70,12) one frame later.
        run_frame(1, 960, 160, 0, 0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
        frame_checks("sim_pend", 1'b0, 0, 0);
        run_frame(0, 0, 0, 0, 0, 1'b1, 1120, 192, 21, 1'b1, 60, 10);
        frame_checks("sim_old", 1'b1, 33, 0);
        run_frame(0, 0, 0, 0, 0, 1'b0, 0, 0, 21, 1'b1, 70, 12);
        frame_checks("sim_new", 1'b1, 33, 0);

        // Reset held 3 clks inside an active line, with a valid strobe that must be dropped.
        frame_bad = 0; frame_marks = 0; frame_rej = 0;
        drive(1'b1, 1'b0, BLANK, 1'b0, 32'd0, 32'd0, BLANK);
        drive(1'b1, 1'b0, BLANK, 1'b0, 32'd0, 32'd0, BLANK);
        drive(1'b0, 1'b0, BLANK, 1'b0, 32'd0, 32'd0, BLANK);
        for (int h = 0; h < 10; h++) drive(1'b0, 1'b1, pix(h, 0), 1'b0, 32'd0, 32'd0, pix(h, 0));
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, pix(10 + i, 0), 1'b1, 32'd1120, 32'd192);
            check($sformatf("midrst%0d_outputs", i),
                  int'({out_vs, out_de, out_rgb, marker_on, coord_reject}), 0);
        end
        rst = 1'b0;
        for (int h = 13; h < 30; h++) drive(1'b0, 1'b1, pix(h, 0), 1'b0, 32'd0, 32'd0, pix(h, 0));
        gap(0, 0, 0, 0, 0);
        frame_checks("midrst_line", 1'b0, 0, 0);
        run_frame(0, 0, 0, 0, 0, 1'b0, 0, 0, 21, 1'b0, 0, 0);
        frame_checks("postrst_f1", 1'b0, 0, 0);
        run_frame(1, 1120, 192, 0, 0, 1'b0, 0, 0, 21, 1'b0, 0, 0);
        frame_checks("postrst_f2", 1'b0, 0, 0);
        run_frame(0, 0, 0, 0, 0, 1'b0, 0, 0, 21, 1'b1, 70, 12);
        frame_checks("postrst_f3", 1'b1, 33, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
